param_reg_file: RTL and testbench

Parametrised register file for the WISC datapath: DEPTH registers of WIDTH bits, two combinational read ports and one synchronous write port. Adds optional write-to-read bypass, an optional hardwired-zero register 0, and a sequential bulk-clear engine that zeroes the array one register per cycle under a request/busy/done handshake. It sits between decode (source/destination selects) and writeback, replacing the fixed 16x16 bitcell array.

---
 rtl/reg_file_pkg.sv | 18 +
 rtl/param_reg_file_if.sv | 37 +++
 rtl/param_register.sv | 21 ++
 rtl/param_reg_file.sv | 98 +++++++++
 tb/tb_param_reg_file.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the parametrised WISC register file.
// State encoding for the bulk-clear engine and the address-width helper.
package reg_file_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } state_t;

  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/param_reg_file_if.sv
// Decode/writeback side bundle of the register file.
// master = issuing pipeline, slave = register file.
interface param_reg_file_if
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);

  localparam int AW = addr_w(DEPTH);

  logic [AW-1:0]    SrcReg1;
  logic [AW-1:0]    SrcReg2;
  logic [AW-1:0]    DstReg;
  logic             WriteReg;
  logic [WIDTH-1:0] DstData;
  logic             ClearReq;
  logic [WIDTH-1:0] SrcData1;
  logic [WIDTH-1:0] SrcData2;
  logic             ClearBusy;
  logic             ClearDone;

  modport master (
    output SrcReg1, SrcReg2, DstReg,
    output WriteReg, DstData, ClearReq,
    input  SrcData1, SrcData2,
    input  ClearBusy, ClearDone
  );

  modport slave (
    input  SrcReg1, SrcReg2, DstReg,
    input  WriteReg, DstData, ClearReq,
    output SrcData1, SrcData2,
    output ClearBusy, ClearDone
  );

endinterface

// File: rtl/param_register.sv
// Single WIDTH-bit storage register with write enable.
// Async active-low reset clears the contents.
module param_register #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/param_reg_file.sv
// DEPTH x WIDTH register file: 2 comb read ports, 1 write port,
// optional bypass / zero register, and a one-reg-per-cycle clear engine.
module param_reg_file
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  param_reg_file_if.slave  bus
);

  localparam int AW = addr_w(DEPTH);
  typedef logic [AW-1:0] addr_t;

  state_t           state;
  addr_t            cnt;
  logic             idle;
  logic             clr;
  logic             dst_zero;
  logic             we_ok;
  logic             byp;
  logic [WIDTH-1:0] dmux;
  logic [DEPTH-1:0] wen;
  logic [WIDTH-1:0] q [DEPTH];

  assign idle     = (state == IDLE);
  assign clr      = (state == CLEAR);
  assign dst_zero = (ZERO_REG != 0) && (bus.DstReg == '0);
  assign we_ok    = idle && bus.WriteReg && !dst_zero;
  assign byp      = (BYPASS != 0) && we_ok;
  assign dmux     = clr ? '0 : bus.DstData;

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    assign wen[i] = clr ? (cnt == addr_t'(i))
                        : (we_ok && bus.DstReg == addr_t'(i));

    param_register #(.WIDTH(WIDTH)) u_reg (
      .clk (clk),
      .rst (rst),
      .en  (wen[i]),
      .d   (dmux),
      .q   (q[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.ClearReq) state <= CLEAR;
        end
        CLEAR: begin
          cnt <= cnt + addr_t'(1);
          if (cnt == addr_t'(DEPTH - 1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ClearBusy = clr;
  assign bus.ClearDone = (state == DONE);

  logic z1, z2, b1, b2;

  assign z1 = (ZERO_REG != 0) && (bus.SrcReg1 == '0);
  assign z2 = (ZERO_REG != 0) && (bus.SrcReg2 == '0);
  assign b1 = byp && (bus.DstReg == bus.SrcReg1) && !z1;
  assign b2 = byp && (bus.DstReg == bus.SrcReg2) && !z2;

  always_comb begin
    bus.SrcData1 = q[bus.SrcReg1];
    unique case (1'b1)
      z1:      bus.SrcData1 = '0;
      b1:      bus.SrcData1 = bus.DstData;
      default: bus.SrcData1 = q[bus.SrcReg1];
    endcase
  end

  always_comb begin
    bus.SrcData2 = q[bus.SrcReg2];
    unique case (1'b1)
      z2:      bus.SrcData2 = '0;
      b2:      bus.SrcData2 = bus.DstData;
      default: bus.SrcData2 = q[bus.SrcReg2];
    endcase
  end

endmodule

// File: tb/tb_param_reg_file.sv
// Directed bench for param_reg_file: bypass and non-bypass instances
// driven in lockstep, table vectors plus clear/reset sequences.
module tb_param_reg_file;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  param_reg_file_if #(.WIDTH(16), .DEPTH(16)) b0 ();
  param_reg_file_if #(.WIDTH(16), .DEPTH(16)) b1 ();

  param_reg_file #(
    .WIDTH(16), .DEPTH(16), .BYPASS(1), .ZERO_REG(1)
  ) u0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  param_reg_file #(
    .WIDTH(16), .DEPTH(16), .BYPASS(0), .ZERO_REG(1)
  ) u1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  typedef struct {
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [3:0]  dst;
    logic        we;
    logic [15:0] dd;
    logic [15:0] e1;
    logic [15:0] e2;
    logic [15:0] n1;
    logic [15:0] n2;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] s1, input logic [3:0] s2,
                       input logic [3:0] dst, input logic we,
                       input logic [15:0] dd, input logic cr);
    b0.SrcReg1 = s1;  b1.SrcReg1 = s1;
    b0.SrcReg2 = s2;  b1.SrcReg2 = s2;
    b0.DstReg  = dst; b1.DstReg  = dst;
    b0.WriteReg = we; b1.WriteReg = we;
    b0.DstData = dd;  b1.DstData = dd;
    b0.ClearReq = cr; b1.ClearReq = cr;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int busy_n;
  int done_n;
  int done_c;

  initial begin
    tests  = 0;
    failed = 0;
    rst    = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    vecs[0] = '{4'd0, 4'd15, 4'd0, 1'b0, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[1] = '{4'd3, 4'd4, 4'd3, 1'b1, 16'hA5A5,
                16'hA5A5, 16'h0000, 16'h0000, 16'h0000};
    vecs[2] = '{4'd3, 4'd3, 4'd0, 1'b0, 16'h0000,
                16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5};
    vecs[3] = '{4'd4, 4'd3, 4'd0, 1'b0, 16'h0000,
                16'h0000, 16'hA5A5, 16'h0000, 16'hA5A5};
    vecs[4] = '{4'd5, 4'd5, 4'd5, 1'b1, 16'h1111,
                16'h1111, 16'h1111, 16'h0000, 16'h0000};
    vecs[5] = '{4'd5, 4'd5, 4'd5, 1'b1, 16'h1234,
                16'h1234, 16'h1234, 16'h1111, 16'h1111};
    vecs[6] = '{4'd0, 4'd0, 4'd0, 1'b1, 16'hFFFF,
                16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[7] = '{4'd0, 4'd5, 4'd0, 1'b0, 16'h0000,
                16'h0000, 16'h1234, 16'h0000, 16'h1234};
    vecs[8] = '{4'd15, 4'd3, 4'd15, 1'b1, 16'hBEEF,
                16'hBEEF, 16'hA5A5, 16'h0000, 16'hA5A5};
    vecs[9] = '{4'd15, 4'd14, 4'd0, 1'b0, 16'h0000,
                16'hBEEF, 16'h0000, 16'hBEEF, 16'h0000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    chk("rst_busy", 32'(b0.ClearBusy), 32'd0);
    chk("rst_done", 32'(b0.ClearDone), 32'd0);
    for (int i = 0; i < 16; i++) begin
      drive(4'(i), 4'(15 - i), 0, 0, 0, 0);
      #1;
      chk($sformatf("rst_rd1[%0d]", i), 32'(b0.SrcData1), 32'd0);
      chk($sformatf("rst_rd2[%0d]", i), 32'(b0.SrcData2), 32'd0);
    end

    cyc();
    for (int v = 0; v < 10; v++) begin
      drive(vecs[v].s1, vecs[v].s2, vecs[v].dst,
            vecs[v].we, vecs[v].dd, 0);
      @(negedge clk);
      chk($sformatf("vec%0d_byp_p1", v), 32'(b0.SrcData1), 32'(vecs[v].e1));
      chk($sformatf("vec%0d_byp_p2", v), 32'(b0.SrcData2), 32'(vecs[v].e2));
      chk($sformatf("vec%0d_nob_p1", v), 32'(b1.SrcData1), 32'(vecs[v].n1));
      chk($sformatf("vec%0d_nob_p2", v), 32'(b1.SrcData2), 32'(vecs[v].n2));
      cyc();
    end

    for (int r = 1; r < 16; r++) begin
      drive(0, 0, 4'(r), 1, 16'(r * 16'h1111), 0);
      cyc();
    end
    drive(10, 15, 0, 0, 0, 0);
    #1;
    chk("fill_r10", 32'(b0.SrcData1), 32'h0000AAAA);
    chk("fill_r15", 32'(b1.SrcData2), 32'h0000FFFF);

    drive(0, 0, 0, 0, 0, 1);
    cyc();
    busy_n = 0;
    done_n = 0;
    done_c = 0;
    for (int c = 1; c <= 24; c++) begin
      if (c == 5) drive(2, 10, 2, 1, 16'h7777, 0);
      else        drive(0, 0, 0, 0, 0, c == 8);
      @(negedge clk);
      if (b0.ClearBusy) busy_n++;
      if (b0.ClearDone) begin
        done_n++;
        done_c = c;
      end
      if (c == 5) begin
        chk("mid_clr_cleared", 32'(b0.SrcData1), 32'd0);
        chk("mid_clr_old", 32'(b0.SrcData2), 32'h0000AAAA);
      end
      cyc();
    end
    chk("clr_busy_cycles", 32'(busy_n), 32'd16);
    chk("clr_done_pulses", 32'(done_n), 32'd1);
    chk("clr_done_cycle", 32'(done_c), 32'd17);
    for (int i = 0; i < 16; i++) begin
      drive(4'(i), 4'(i), 0, 0, 0, 0);
      #1;
      chk($sformatf("post_clr[%0d]", i), 32'(b0.SrcData1), 32'd0);
      chk($sformatf("post_clr_nb[%0d]", i), 32'(b1.SrcData2), 32'd0);
    end

    cyc();
    drive(0, 0, 10, 1, 16'h5A5A, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 1);
    cyc();
    drive(10, 10, 0, 0, 0, 0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 6) chk("pre_rst_busy", 32'(b0.ClearBusy), 32'd1);
      cyc();
    end
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(b0.ClearBusy), 32'd0);
    chk("mid_rst_done", 32'(b0.ClearDone), 32'd0);
    chk("mid_rst_rd", 32'(b0.SrcData1), 32'd0);
    chk("mid_rst_rd_nb", 32'(b1.SrcData2), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    busy_n = 0;
    done_n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (b0.ClearBusy) busy_n++;
      if (b0.ClearDone) done_n++;
    end
    chk("post_rst_busy", 32'(busy_n), 32'd0);
    chk("post_rst_done", 32'(done_n), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
